// File: rtl/k005297_cmdreg.sv
// CPU command/status register block for the K005297 bubble controller.
// Launches page read/write requests into the controller FSM and reports their outcome to the CPU.
module k005297_cmdreg #(
    parameter int              PAGE_W = 12,
    parameter int              TO_W   = 16,
    parameter logic [TO_W-1:0] TO_VAL = 16'hFFFF
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_CLK2M_PCEN_n,
    input  logic              i_CPU_CS_n,
    input  logic              i_CPU_WR_n,
    input  logic              i_CPU_RD_n,
    input  logic [1:0]        i_CPU_ADDR,
    input  logic [7:0]        i_CPU_DIN,
    output logic [7:0]        o_CPU_DOUT,
    output logic              o_IRQ_n,
    output logic              o_CMDREG_RDREQ,
    output logic              o_CMDREG_WRREQ,
    output logic [PAGE_W-1:0] o_PAGE_NUM,
    input  logic              i_CMD_ACCEPTED_n,
    input  logic              i_CMDREG_RST_n,
    input  logic              i_FSMERR_RESTART_n,
    input  logic              i_SYS_RUN_FLAG,
    input  logic              i_SYS_ERR_FLAG
);

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        strb_meta_q, strb_meta_d;
    logic [2:0]        strb_sync_q, strb_sync_d;
    logic              wr_hi_q, wr_hi_d;
    logic              rd_hi_q, rd_hi_d;
    logic              rdreq_q, rdreq_d;
    logic              wrreq_q, wrreq_d;
    logic              ien_q, ien_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic              irqpend_q, irqpend_d;
    logic              run_q, run_d;
    logic              sys_err_q, sys_err_d;
    logic              irq_n_q, irq_n_d;
    logic [7:0]        dout_q, dout_d;

    logic       busy, tick, wr_hi, rd_hi, wr_commit, status_clr;
    logic       done_set, err_set, illegal_set, timeout_set;
    logic [7:0] status, rd_data;

    assign busy       = (state_q != ST_IDLE);
    assign tick       = ~i_CLK2M_PCEN_n;
    // Synchronised strobes are ordered {CS, WR, RD}; the end of a strobe is the rising edge of the OR.
    assign wr_hi      = strb_sync_q[2] | strb_sync_q[1];
    assign rd_hi      = strb_sync_q[2] | strb_sync_q[0];
    assign wr_commit  = wr_hi & ~wr_hi_q;
    assign status_clr = rd_hi & ~rd_hi_q & (i_CPU_ADDR == 2'd3);
    assign status     = {irqpend_q, run_q, sys_err_q, timeout_q, illegal_q, err_q, done_q, busy};

    always_comb begin
        rd_data = 8'hFF;
        case (i_CPU_ADDR)
            2'd0: rd_data = {ien_q, 5'b0, wrreq_q, rdreq_q};
            2'd1: rd_data = page_q[7:0];
            2'd2: rd_data = 8'(page_q[PAGE_W-1:8]);
            2'd3: rd_data = status;
            default: rd_data = 8'hFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        strb_meta_d = {i_CPU_CS_n, i_CPU_WR_n, i_CPU_RD_n};
        strb_sync_d = strb_meta_q;
        wr_hi_d     = wr_hi;
        rd_hi_d     = rd_hi;
        rdreq_d     = rdreq_q;
        wrreq_d     = wrreq_q;
        ien_d       = ien_q;
        page_d      = page_q;
        wd_d        = wd_q;
        run_d       = run_q;
        sys_err_d   = sys_err_q;
        done_set    = 1'b0;
        err_set     = 1'b0;
        illegal_set = 1'b0;
        timeout_set = 1'b0;

        if (wr_commit) begin
            case (i_CPU_ADDR)
                2'd0: begin
                    ien_d = i_CPU_DIN[7];
                    if (busy || (i_CPU_DIN[0] && i_CPU_DIN[1])) begin
                        illegal_set = 1'b1;
                    end else if (i_CPU_DIN[0] ^ i_CPU_DIN[1]) begin
                        if (run_q && !sys_err_q) begin
                            rdreq_d = i_CPU_DIN[0];
                            wrreq_d = i_CPU_DIN[1];
                            wd_d    = '0;
                            state_d = ST_PEND;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                2'd1: begin
                    if (busy) illegal_set = 1'b1;
                    else      page_d[7:0] = i_CPU_DIN;
                end
                2'd2: begin
                    if (busy) illegal_set = 1'b1;
                    else      page_d[PAGE_W-1:8] = i_CPU_DIN[PAGE_W-9:0];
                end
                default: ;
            endcase
        end

        // FSM strobes are only meaningful on 2 MHz enable ticks; aborts outrank acceptance and completion.
        if (tick) begin
            run_d     = i_SYS_RUN_FLAG;
            sys_err_d = i_SYS_ERR_FLAG;
            if (busy) begin
                if (!i_FSMERR_RESTART_n || !i_SYS_RUN_FLAG) begin
                    rdreq_d = 1'b0;
                    wrreq_d = 1'b0;
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end else if (state_q == ST_PEND) begin
                    if (!i_CMD_ACCEPTED_n) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                        if ((TO_VAL != '0) && (wd_d == TO_VAL)) begin
                            rdreq_d     = 1'b0;
                            wrreq_d     = 1'b0;
                            err_set     = 1'b1;
                            timeout_set = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end
                end else if (!i_CMDREG_RST_n) begin
                    rdreq_d  = 1'b0;
                    wrreq_d  = 1'b0;
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        end

        done_d    = (done_q    & ~status_clr) | done_set;
        err_d     = (err_q     & ~status_clr) | err_set;
        illegal_d = (illegal_q & ~status_clr) | illegal_set;
        timeout_d = (timeout_q & ~status_clr) | timeout_set;
        irqpend_d = (irqpend_q & ~status_clr) | done_set | err_set;
        irq_n_d   = ~(irqpend_q & ien_q);
        dout_d    = (!strb_sync_q[2] && !strb_sync_q[0]) ? rd_data : 8'hFF;
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q     <= ST_IDLE;
            strb_meta_q <= 3'b111;
            strb_sync_q <= 3'b111;
            wr_hi_q     <= 1'b1;
            rd_hi_q     <= 1'b1;
            rdreq_q     <= 1'b0;
            wrreq_q     <= 1'b0;
            ien_q       <= 1'b0;
            page_q      <= '0;
            wd_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            irqpend_q   <= 1'b0;
            run_q       <= 1'b0;
            sys_err_q   <= 1'b0;
            irq_n_q     <= 1'b1;
            dout_q      <= 8'hFF;
        end else begin
            state_q     <= state_d;
            strb_meta_q <= strb_meta_d;
            strb_sync_q <= strb_sync_d;
            wr_hi_q     <= wr_hi_d;
            rd_hi_q     <= rd_hi_d;
            rdreq_q     <= rdreq_d;
            wrreq_q     <= wrreq_d;
            ien_q       <= ien_d;
            page_q      <= page_d;
            wd_q        <= wd_d;
            done_q      <= done_d;
            err_q       <= err_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            irqpend_q   <= irqpend_d;
            run_q       <= run_d;
            sys_err_q   <= sys_err_d;
            irq_n_q     <= irq_n_d;
            dout_q      <= dout_d;
        end
    end

    assign o_CPU_DOUT     = dout_q;
    assign o_IRQ_n        = irq_n_q;
    assign o_CMDREG_RDREQ = rdreq_q;
    assign o_CMDREG_WRREQ = wrreq_q;
    assign o_PAGE_NUM     = page_q;

endmodule

// File: tb/tb_k005297_cmdreg.sv
// Directed bench for k005297_cmdreg: CPU register accesses and hand-driven FSM strobes.
// Watchdog limit is shortened to 16 ticks so the timeout path is reachable.
module tb_k005297_cmdreg;

    logic        mclk = 1'b0;
    logic        rst;
    logic        pcenN;
    logic        csN, wrN, rdN;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        irqN;
    logic        rdReq, wrReq;
    logic [11:0] pageNum;
    logic        acceptedN, cmdRstN, fsmErrN, sysRun, sysErr;

    int testsRun    = 0;
    int testsFailed = 0;
    logic [7:0] rdVal;

    k005297_cmdreg #(.PAGE_W(12), .TO_W(16), .TO_VAL(16'd16)) dut (
        .i_MCLK             (mclk),
        .i_RST              (rst),
        .i_CLK2M_PCEN_n     (pcenN),
        .i_CPU_CS_n         (csN),
        .i_CPU_WR_n         (wrN),
        .i_CPU_RD_n         (rdN),
        .i_CPU_ADDR         (addr),
        .i_CPU_DIN          (din),
        .o_CPU_DOUT         (dout),
        .o_IRQ_n            (irqN),
        .o_CMDREG_RDREQ     (rdReq),
        .o_CMDREG_WRREQ     (wrReq),
        .o_PAGE_NUM         (pageNum),
        .i_CMD_ACCEPTED_n   (acceptedN),
        .i_CMDREG_RST_n     (cmdRstN),
        .i_FSMERR_RESTART_n (fsmErrN),
        .i_SYS_RUN_FLAG     (sysRun),
        .i_SYS_ERR_FLAG     (sysErr)
    );

    always #5 mclk = ~mclk;

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CPU bus write: strobe held for several clocks, address/data held past the commit.
    task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d);
        addr = a;
        din  = d;
        csN  = 1'b0;
        wrN  = 1'b0;
        step(4);
        csN  = 1'b1;
        wrN  = 1'b1;
        step(5);
    endtask

    task automatic readReg(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        csN  = 1'b0;
        rdN  = 1'b0;
        step(5);
        d    = dout;
        csN  = 1'b1;
        rdN  = 1'b1;
        step(5);
    endtask

    // One single-cycle 2 MHz enable tick with whatever FSM strobes are currently driven.
    task automatic fsmTick();
        pcenN = 1'b0;
        step(1);
        pcenN = 1'b1;
        step(1);
    endtask

    initial begin
        rst = 1'b1; pcenN = 1'b1; csN = 1'b1; wrN = 1'b1; rdN = 1'b1;
        addr = 2'd0; din = 8'h00;
        acceptedN = 1'b1; cmdRstN = 1'b1; fsmErrN = 1'b1; sysRun = 1'b1; sysErr = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);

        checkOutput("reset_rdreq", 16'(rdReq), 16'h0);
        checkOutput("reset_wrreq", 16'(wrReq), 16'h0);
        checkOutput("reset_irq_n", 16'(irqN), 16'h1);
        checkOutput("reset_dout", 16'(dout), 16'h00FF);
        checkOutput("reset_page", 16'(pageNum), 16'h0000);

        // Normal read request with IEN set.
        fsmTick();
        applyStimulus(2'd1, 8'h23);
        applyStimulus(2'd2, 8'h01);
        checkOutput("page_0x123", 16'(pageNum), 16'h0123);
        readReg(2'd2, rdVal);
        checkOutput("read_page_hi", 16'(rdVal), 16'h0001);
        applyStimulus(2'd0, 8'h81);
        checkOutput("rd_rdreq_set", 16'(rdReq), 16'h1);
        checkOutput("rd_wrreq_clr", 16'(wrReq), 16'h0);
        readReg(2'd0, rdVal);
        checkOutput("read_cmd", 16'(rdVal), 16'h0081);
        readReg(2'd3, rdVal);
        checkOutput("status_pend", 16'(rdVal), 16'h0041);
        acceptedN = 1'b0; fsmTick(); acceptedN = 1'b1;
        checkOutput("rdreq_active", 16'(rdReq), 16'h1);
        cmdRstN = 1'b0; fsmTick(); cmdRstN = 1'b1;
        checkOutput("rdreq_done", 16'(rdReq), 16'h0);
        checkOutput("irq_after_done", 16'(irqN), 16'h0);
        readReg(2'd3, rdVal);
        checkOutput("status_done", 16'(rdVal), 16'h00C2);
        readReg(2'd3, rdVal);
        checkOutput("status_reread", 16'(rdVal), 16'h0040);
        checkOutput("irq_cleared", 16'(irqN), 16'h1);

        // Illegal command, then a page write while pending.
        applyStimulus(2'd0, 8'h03);
        checkOutput("illegal_no_req", 16'({rdReq, wrReq}), 16'h0);
        readReg(2'd3, rdVal);
        checkOutput("status_illegal", 16'(rdVal), 16'h0048);
        applyStimulus(2'd0, 8'h02);
        checkOutput("wr_wrreq_set", 16'(wrReq), 16'h1);
        applyStimulus(2'd1, 8'h55);
        checkOutput("page_frozen", 16'(pageNum), 16'h0123);
        readReg(2'd3, rdVal);
        checkOutput("status_busy_illegal", 16'(rdVal), 16'h0049);

        // Watchdog: no acceptance, request must hold for 15 ticks and drop on the 16th.
        repeat (15) fsmTick();
        checkOutput("wd_tick15", 16'(wrReq), 16'h1);
        fsmTick();
        checkOutput("wd_tick16", 16'(wrReq), 16'h0);
        checkOutput("wd_irq_masked", 16'(irqN), 16'h1);
        // ERR raises IRQPEND even though IEN is clear.
        readReg(2'd3, rdVal);
        checkOutput("status_timeout", 16'(rdVal), 16'h00D4);

        // FSM restart and completion on the same tick: restart wins.
        applyStimulus(2'd0, 8'h81);
        acceptedN = 1'b0; fsmTick(); acceptedN = 1'b1;
        fsmErrN = 1'b0; cmdRstN = 1'b0; fsmTick(); fsmErrN = 1'b1; cmdRstN = 1'b1;
        checkOutput("prio_rdreq", 16'(rdReq), 16'h0);
        checkOutput("prio_irq", 16'(irqN), 16'h0);
        readReg(2'd3, rdVal);
        checkOutput("status_prio", 16'(rdVal), 16'h00C4);

        // Controller not running.
        sysRun = 1'b0; fsmTick();
        applyStimulus(2'd0, 8'h01);
        checkOutput("norun_no_req", 16'(rdReq), 16'h0);
        readReg(2'd3, rdVal);
        checkOutput("status_norun", 16'(rdVal), 16'h0084);
        sysRun = 1'b1; fsmTick();
        applyStimulus(2'd0, 8'h01);
        acceptedN = 1'b0; fsmTick(); acceptedN = 1'b1;
        checkOutput("active_rdreq", 16'(rdReq), 16'h1);
        sysRun = 1'b0; fsmTick();
        checkOutput("run_drop_rdreq", 16'(rdReq), 16'h0);
        readReg(2'd3, rdVal);
        checkOutput("status_run_drop", 16'(rdVal), 16'h0084);

        // Completion strobe in IDLE does nothing.
        sysRun = 1'b1; fsmTick();
        cmdRstN = 1'b0; fsmTick(); cmdRstN = 1'b1;
        readReg(2'd3, rdVal);
        checkOutput("idle_cmdrst", 16'(rdVal), 16'h0040);

        // Reset while active.
        applyStimulus(2'd0, 8'h82);
        acceptedN = 1'b0; fsmTick(); acceptedN = 1'b1;
        checkOutput("pre_rst_wrreq", 16'(wrReq), 16'h1);
        sysRun = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        checkOutput("rst_reqs", 16'({rdReq, wrReq}), 16'h0);
        checkOutput("rst_irq_n", 16'(irqN), 16'h1);
        readReg(2'd3, rdVal);
        checkOutput("rst_status", 16'(rdVal), 16'h0000);

        // Upper page byte: only PAGE_W-8 bits stored, rest read as zero.
        applyStimulus(2'd2, 8'hAB);
        checkOutput("page_hi_trunc", 16'(pageNum), 16'h0B00);
        readReg(2'd2, rdVal);
        checkOutput("read_page_hi_trunc", 16'(rdVal), 16'h000B);
        checkOutput("idle_dout", 16'(dout), 16'h00FF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
